// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, aligner FSM states and
// the 10b->8b data / token-to-symbol decode helpers.
package tmds_pkg;

  localparam logic [9:0] TokCtrl00 = 10'b1101010100;
  localparam logic [9:0] TokCtrl01 = 10'b0010101011;
  localparam logic [9:0] TokCtrl10 = 10'b0101010100;
  localparam logic [9:0] TokCtrl11 = 10'b1010101011;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StSlip   = 2'd1,
    StLocked = 2'd2
  } state_e;

  function automatic logic is_token(input logic [9:0] w);
    return (w == TokCtrl00) || (w == TokCtrl01) || (w == TokCtrl10) || (w == TokCtrl11);
  endfunction

  function automatic logic [1:0] token_symbol(input logic [9:0] w);
    logic [1:0] s;
    s = 2'b00;
    case (w)
      TokCtrl01: s = 2'b01;
      TokCtrl10: s = 2'b10;
      TokCtrl11: s = 2'b11;
      default:   s = 2'b00;
    endcase
    return s;
  endfunction

  // bit9 undoes the DC-balance inversion, bit8 selects XOR vs XNOR chaining
  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] q;
    d    = w[9] ? ~w[7:0] : w[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Two-word history of the deserializer output and the bit-slip window select.
module tmds_word_aligner (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] raw_word,
  input  logic [3:0] slip,
  output logic [9:0] aligned
);

  logic [9:0]  w1_q;
  logic [9:0]  w0_q;
  logic [19:0] shifted;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      w1_q <= '0;
      w0_q <= '0;
    end else begin
      w1_q <= raw_word;
      w0_q <= w1_q;
    end
  end

  // w0 holds the older bits, so the window walks forward in time as slip grows
  assign shifted = {w1_q, w0_q} >> slip;
  assign aligned = shifted[9:0];

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel receiver: bit-slip word alignment on control-token runs plus
// 8b/10b decode. Define TMDS_DECODER_ERRCNT_EN to count short control runs in err_cnt.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_RUN     = 8,
  parameter int unsigned SLIP_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT = 4096,
  parameter int unsigned SETTLE       = 2
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  raw_word,
  output logic [7:0]  data,
  output logic [1:0]  ctrl,
  output logic        de,
  output logic        locked,
  output logic [3:0]  slip,
  output logic [15:0] err_cnt
);

  localparam int unsigned RunW    = $clog2(LOCK_RUN + 1);
  localparam int unsigned ToW     = $clog2(SLIP_TIMEOUT + 1);
  localparam int unsigned LossW   = $clog2(LOSS_TIMEOUT + 1);
  localparam int unsigned SettleW = $clog2(SETTLE + 1);

  state_e              state_q;
  logic [RunW-1:0]     run_q;
  logic [ToW-1:0]      to_q;
  logic [LossW-1:0]    loss_q;
  logic [SettleW-1:0]  settle_q;
  logic [3:0]          slip_q;
  logic                locked_q;
  logic [7:0]          data_q;
  logic [1:0]          ctrl_q;
  logic                de_q;

  logic [9:0]          aligned;
  logic                is_tok;
  logic [1:0]          sym;
  logic [7:0]          dec;
  logic                run_hit;
  logic [RunW-1:0]     run_next;
  logic [3:0]          slip_inc;

  tmds_word_aligner u_aligner (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .raw_word  (raw_word),
    .slip      (slip_q),
    .aligned   (aligned)
  );

  always_comb begin
    is_tok   = is_token(aligned);
    sym      = token_symbol(aligned);
    dec      = tmds_decode(aligned);
    // Fires only on the token that brings the run up to LOCK_RUN, not while saturated
    run_hit  = is_tok && (run_q == RunW'(LOCK_RUN - 1));
    run_next = '0;
    if (is_tok) begin
      run_next = (run_q == RunW'(LOCK_RUN)) ? run_q : run_q + 1'b1;
    end
    slip_inc = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q  <= StSearch;
      run_q    <= '0;
      to_q     <= '0;
      loss_q   <= '0;
      settle_q <= '0;
      slip_q   <= '0;
      locked_q <= 1'b0;
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
    end else begin
      if (state_q == StLocked) begin
        if (is_tok) begin
          de_q   <= 1'b0;
          ctrl_q <= sym;
          data_q <= '0;
        end else begin
          de_q   <= 1'b1;
          data_q <= dec;
        end
      end else begin
        de_q   <= 1'b0;
        ctrl_q <= '0;
        data_q <= '0;
      end

      unique case (state_q)
        StSearch: begin
          run_q <= run_next;
          if (run_hit) begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
            loss_q   <= '0;
            to_q     <= '0;
          end else if (to_q == ToW'(SLIP_TIMEOUT - 1)) begin
            state_q  <= StSlip;
            slip_q   <= slip_inc;
            to_q     <= '0;
            settle_q <= '0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StSlip: begin
          // Window contents are stale for a couple of cycles after a slip change
          run_q <= '0;
          to_q  <= '0;
          if (settle_q == SettleW'(SETTLE - 1)) begin
            state_q  <= StSearch;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StLocked: begin
          run_q <= run_next;
          if (run_hit) begin
            loss_q <= '0;
          end else if (loss_q == LossW'(LOSS_TIMEOUT - 1)) begin
            state_q  <= StSlip;
            locked_q <= 1'b0;
            slip_q   <= slip_inc;
            loss_q   <= '0;
            settle_q <= '0;
          end else begin
            loss_q <= loss_q + 1'b1;
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

`ifdef TMDS_DECODER_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      err_q <= '0;
    end else if ((state_q == StLocked) && !is_tok && (run_q != '0) &&
                 (run_q < RunW'(LOCK_RUN)) && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

  assign data   = data_q;
  assign ctrl   = ctrl_q;
  assign de     = de_q;
  assign locked = locked_q;
  assign slip   = slip_q;

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the pixel-domain TMDS channel encoder; one instance per TMDS channel (R, G, B).
- Takes 10-bit words from an external deserializer whose word boundary is arbitrary.
- Finds word alignment by bit-slipping against control-token runs, then decodes the 8b/10b TMDS data and the 2-bit control symbols.
- Blue instance ctrl = {vsync, hsync}; de feeds the downstream video timing recovery.

Parameters:
- LOCK_RUN, 8, consecutive control tokens at one slip position required to declare lock.
- SLIP_TIMEOUT, 2048, SEARCH cycles without lock before advancing slip (> one 800-pixel line).
- LOSS_TIMEOUT, 4096, LOCKED cycles without a control run >= LOCK_RUN before dropping lock.
- SETTLE, 2, cycles waited after a slip change before counting resumes.

Ports:
- clk_pixel  in  1  pixel clock, 25 MHz; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- raw_word  in  10  deserialized word, bit0 = earliest received bit (LSB-first, matches transmitter shift order).
- data  out  8  decoded video byte.
- ctrl  out  2  decoded control symbol {CD1,CD0}.
- de  out  1  1 = data valid (video word), 0 = control period.
- locked  out  1  alignment lock.
- slip  out  4  current bit offset 0..9.
- err_cnt  out  16  short-control-run error count (see Optional Feature).

Behaviour:
- Reset: data=0, ctrl=00, de=0, locked=0, slip=0, err_cnt=0, state=SEARCH, all counters 0.
- Window: w1 <= raw_word; w0 <= w1 every cycle. aligned = {w1,w0}[slip+9:slip], combinational.
- Latency: word presented on raw_word at cycle t appears on the outputs at t+2.
- Token match: aligned equal to
  - 1101010100 -> 00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
  - anything else is a data word.
- Data decode: d = aligned[9] ? ~aligned[7:0] : aligned[7:0]; out[0] = d[0]; out[i] = aligned[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i = 1..7.
- Output register, LOCKED only:
  - token: de=0, ctrl=symbol, data=0.
  - data word: de=1, data=decoded, ctrl holds its last value.
- Output register, not LOCKED: de=0, data=0, ctrl=00.
- run counter: +1 per token (saturating at LOCK_RUN); cleared on a data word.
- SEARCH:
  - run reaches LOCK_RUN -> LOCKED (locked=1 the next cycle); loss counter cleared.
  - Else timeout counter +1; at SLIP_TIMEOUT-1 -> SLIP, with slip = (slip==9) ? 0 : slip+1.
- SLIP:
  - Wait SETTLE cycles with run and timeout held at 0, then -> SEARCH.
  - Only state that changes slip; wrap from 9 to 0.
- LOCKED:
  - loss counter +1 each cycle; cleared when run reaches LOCK_RUN.
  - At LOSS_TIMEOUT-1 -> SLIP (slip advanced), locked=0 the next cycle.
  - slip is frozen while LOCKED.
- Simultaneous events:
  - run reaching LOCK_RUN in the same cycle the timeout expires: lock wins.
  - Same coincidence in LOCKED: loss counter clears, lock held.
- reset asserted mid-operation returns everything to reset values on the next edge, regardless of state.
- Counter widths: ceil(log2(max+1)); no wrap, the counters saturate or clear as stated.

Optional Feature:
- Macro: TMDS_DECODER_ERRCNT_EN.
- Defined:
  - In LOCKED, when a data word ends a token run of length 1..LOCK_RUN-1, err_cnt increments by 1, saturating at 16'hFFFF.
  - err_cnt clears on reset only.
- Undefined: err_cnt is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package tmds_pkg:
  - four control-token constants;
  - state enum (SEARCH, SLIP, LOCKED);
  - decode function (10b -> 8b);
  - token-to-symbol function.
- Sub-module tmds_word_aligner: w1/w0 registers plus the slip mux, output aligned[9:0].
- FSM and output register remain in the top module.

Test Plan:
- Bitstream of 800-pixel lines (160 tokens 1101010100, 640 data words for 0x5A) rotated by 3 bits, from reset -> slip advances 0,1,2,3 and stops at 3; locked=1; then de=1 with data=0x5A for 640 cycles and ctrl=00 during blanking.
- Aligned input, 16 tokens 1010101011 then data word 0100000000 -> lock after 8 tokens; ctrl=11; the data word decodes to 0x00 with de=1, 2 cycles after entry.
- Sweep all 256 bytes through the encoder model at slip=0 -> data equals the byte; de=1 on every data cycle; no mismatch.
- After lock, feed only data words for 4096 cycles -> locked falls; slip increments by 1; outputs forced to de=0, data=0, ctrl=00.
- With TMDS_DECODER_ERRCNT_EN defined, while locked: token run of 3 followed by data -> err_cnt increments from 0 to 1. Without the macro, err_cnt stays 0.
- Assert reset while locked at slip=7 -> next cycle locked=0, slip=0, de=0, err_cnt=0.
